// File: rtl/boot_sig_gate.sv
// boot_sig_gate: MMIO boot signature gate. Collects public key, signature
// and hash words, checks the key against a provisioned table with
// revocation, then drives an external verifier over start/done with an
// attempt-limited lockout.
// Optional feature: define BOOT_SIG_TIMEOUT_EN to add a verifier timeout
// (err 5 after TIMEOUT_CYC VERIFY cycles without done).
module boot_sig_gate #(
  parameter int unsigned PK_WORDS     = 8,
  parameter int unsigned SIG_WORDS    = 16,
  parameter int unsigned HASH_WORDS   = 8,
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned TIMEOUT_CYC  = 65536
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             lock_i,
  input  logic                             wr_en,
  input  logic                             wr_addr,
  input  logic [31:0]                      wr_data,
  input  logic [NUM_KEYS*PK_WORDS*32-1:0]  key_table_i,
  input  logic [NUM_KEYS-1:0]              key_revoked_i,
  output logic [31:0]                      rd_data,
  output logic                             sig_ok,
  output logic                             vfy_start_o,
  output logic [PK_WORDS*32-1:0]           vfy_pubkey_o,
  output logic [SIG_WORDS*32-1:0]          vfy_sig_o,
  output logic [HASH_WORDS*32-1:0]         vfy_hash_o,
  input  logic                             vfy_done_i,
  input  logic                             vfy_ok_i
);

  localparam int unsigned PK_W   = PK_WORDS * 32;
  localparam int unsigned SIG_W  = SIG_WORDS * 32;
  localparam int unsigned HASH_W = HASH_WORDS * 32;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_READY,
    ST_VERIFY,
    ST_PASS,
    ST_FAIL,
    ST_LOCKOUT
  } state_t;

  state_t              state;
  logic [PK_W-1:0]     pk_buf;
  logic [SIG_W-1:0]    sig_buf;
  logic [HASH_W-1:0]   hash_buf;
  logic [1:0]          seg;
  logic [7:0]          idx;
  logic [3:0]          err;
  logic [3:0]          attempts;
  logic                vfy_start_q;

  logic                wr_acc;
  logic                data_wr;
  logic                ctrl_wr;
  logic                ctrl_start;
  logic                ctrl_abort;
  logic [3:0]          key_id;
  logic                key_id_bad;
  logic [PK_W-1:0]     sel_key;
  logic                sel_revoked;
  logic                seg_last;
  logic [3:0]          att_inc;
  logic                att_lock;

  assign wr_acc     = wr_en && !lock_i;
  assign data_wr    = wr_acc && !wr_addr;
  assign ctrl_wr    = wr_acc && wr_addr;
  assign ctrl_start = wr_data[0];
  assign ctrl_abort = wr_data[1];
  assign key_id     = wr_data[11:8];
  assign key_id_bad = 32'(key_id) >= NUM_KEYS;
  assign att_inc    = attempts + 4'd1;
  assign att_lock   = att_inc >= 4'(MAX_ATTEMPTS);

  // Select the addressed key slot and its revocation bit (zero if out of range)
  always_comb begin
    sel_key     = '0;
    sel_revoked = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (key_id == 4'(k)) begin
        sel_key     = key_table_i[k*PK_W +: PK_W];
        sel_revoked = key_revoked_i[k];
      end
    end
  end

  // Detect the final word of the segment currently being filled
  always_comb begin
    case (seg)
      2'd0:    seg_last = (idx == 8'(PK_WORDS - 1));
      2'd1:    seg_last = (idx == 8'(SIG_WORDS - 1));
      default: seg_last = (idx == 8'(HASH_WORDS - 1));
    endcase
  end

`ifdef BOOT_SIG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] vcyc;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Main controller: MMIO writes, key checks, verifier handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_COLLECT;
      pk_buf      <= '0;
      sig_buf     <= '0;
      hash_buf    <= '0;
      seg         <= '0;
      idx         <= '0;
      err         <= '0;
      attempts    <= '0;
      vfy_start_q <= 1'b0;
`ifdef BOOT_SIG_TIMEOUT_EN
      vcyc        <= '0;
`endif
    end else begin
      vfy_start_q <= 1'b0;
      if (ctrl_wr && ctrl_abort) begin
        if (state inside {ST_COLLECT, ST_READY, ST_FAIL}) begin
          pk_buf   <= '0;
          sig_buf  <= '0;
          hash_buf <= '0;
          seg      <= '0;
          idx      <= '0;
          err      <= '0;
          state    <= ST_COLLECT;
        end
      end else if (ctrl_wr && ctrl_start) begin
        if (state == ST_READY) begin
          if (key_id_bad) begin
            err   <= 4'd1;
            state <= ST_FAIL;
          end else if (sel_revoked) begin
            err   <= 4'd2;
            state <= ST_FAIL;
          end else if (pk_buf != sel_key) begin
            err   <= 4'd3;
            state <= ST_FAIL;
          end else begin
            state       <= ST_VERIFY;
            vfy_start_q <= 1'b1;
`ifdef BOOT_SIG_TIMEOUT_EN
            vcyc        <= TW'(1);
`endif
          end
        end else begin
          err <= 4'd6;
        end
      end else if (data_wr && state == ST_COLLECT) begin
        case (seg)
          2'd0:    pk_buf   <= {wr_data, pk_buf[PK_W-1:32]};
          2'd1:    sig_buf  <= {wr_data, sig_buf[SIG_W-1:32]};
          default: hash_buf <= {wr_data, hash_buf[HASH_W-1:32]};
        endcase
        if (seg_last) begin
          seg <= seg + 2'd1;
          idx <= '0;
          if (seg == 2'd2) state <= ST_READY;
        end else begin
          idx <= idx + 8'd1;
        end
      end

      // Verifier completion is evaluated after the write path so that a
      // done in the same cycle as a stray start owns the error code.
      if (state == ST_VERIFY) begin
        if (vfy_done_i) begin
          if (vfy_ok_i) begin
            state <= ST_PASS;
          end else begin
            err      <= 4'd4;
            attempts <= att_inc;
            state    <= att_lock ? ST_LOCKOUT : ST_FAIL;
          end
        end
`ifdef BOOT_SIG_TIMEOUT_EN
        else if (vcyc == TW'(TIMEOUT_CYC)) begin
          err      <= 4'd5;
          attempts <= att_inc;
          state    <= att_lock ? ST_LOCKOUT : ST_FAIL;
        end else begin
          vcyc <= vcyc + TW'(1);
        end
`endif
      end
    end
  end

  assign sig_ok       = (state == ST_PASS);
  assign vfy_start_o  = vfy_start_q;
  assign vfy_pubkey_o = pk_buf;
  assign vfy_sig_o    = sig_buf;
  assign vfy_hash_o   = hash_buf;
  assign rd_data      = {(state inside {ST_PASS, ST_FAIL, ST_LOCKOUT}),
                         (state == ST_PASS),
                         (state == ST_LOCKOUT),
                         1'b0, err, attempts, seg, 10'd0, idx};

endmodule

// File: tb/tb_boot_sig_gate.sv
// Testbench for boot_sig_gate: lockstep scoreboard against a word-count
// based reference model, directed scenarios followed by random traffic.
module tb_boot_sig_gate;

  localparam int PKW = 8, SGW = 16, HSW = 8, NK = 4, MA = 3, TO = 16;
  localparam int TOT = PKW + SGW + HSW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lock_i = 1'b0, wr_en = 1'b0, wr_addr = 1'b0;
  logic [31:0] wr_data = '0;
  logic [NK*PKW*32-1:0] key_table_i;
  logic [NK-1:0] key_revoked_i = '0;
  logic [31:0] rd_data;
  logic sig_ok, vfy_start_o;
  logic [PKW*32-1:0] vfy_pubkey_o;
  logic [SGW*32-1:0] vfy_sig_o;
  logic [HSW*32-1:0] vfy_hash_o;
  logic vfy_done_i = 1'b0, vfy_ok_i = 1'b0;

  boot_sig_gate #(.PK_WORDS(PKW), .SIG_WORDS(SGW), .HASH_WORDS(HSW),
                  .NUM_KEYS(NK), .MAX_ATTEMPTS(MA), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .lock_i(lock_i), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .key_table_i(key_table_i), .key_revoked_i(key_revoked_i),
    .rd_data(rd_data), .sig_ok(sig_ok), .vfy_start_o(vfy_start_o),
    .vfy_pubkey_o(vfy_pubkey_o), .vfy_sig_o(vfy_sig_o), .vfy_hash_o(vfy_hash_o),
    .vfy_done_i(vfy_done_i), .vfy_ok_i(vfy_ok_i));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned     cyc;
    logic [31:0]     rd;
    logic            ok;
    logic            st;
    logic [PKW*32-1:0] pk;
    logic [SGW*32-1:0] sg;
    logic [HSW*32-1:0] hs;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;
  logic lock_req = 1'b0;
  logic [NK-1:0] rev_req = '0;
  logic [31:0] ktab [NK][PKW];

  // Reference model: progress is a count of accepted words plus outcome flags
  int m_w, m_err, m_att, m_vc;
  bit m_ver, m_done, m_ok, m_lock, m_start;
  logic [31:0] mw [TOT];

  function automatic void check(string nm, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endfunction

  function automatic int clamp(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_reset();
    m_w = 0; m_err = 0; m_att = 0; m_vc = 0;
    m_ver = 0; m_done = 0; m_ok = 0; m_lock = 0; m_start = 0;
  endfunction

  function automatic void verify_fail(int code);
    m_err = code; m_att++; m_ver = 0; m_done = 1;
    if (m_att >= MA) m_lock = 1;
  endfunction

  function automatic bit pk_matches(int kid);
    for (int i = 0; i < PKW; i++) if (mw[i] != ktab[kid][i]) return 0;
    return 1;
  endfunction

  function automatic void model_step(bit we, bit ad, logic [31:0] d, bit dn, bit ok);
    bit was_ver = m_ver;
    int kid;
    m_start = 0;
    if (we && !lock_i) begin
      if (!ad) begin
        if (!m_ver && !m_done && m_w < TOT) begin mw[m_w] = d; m_w++; end
      end else if (d[1]) begin
        if (!m_ver && !(m_done && m_ok) && !m_lock) begin
          m_w = 0; m_err = 0; m_done = 0; m_ok = 0;
        end
      end else if (d[0]) begin
        if (m_w == TOT && !m_done && !m_ver) begin
          kid = int'(d[11:8]);
          if (kid >= NK) begin m_err = 1; m_done = 1; end
          else if (key_revoked_i[kid]) begin m_err = 2; m_done = 1; end
          else if (!pk_matches(kid)) begin m_err = 3; m_done = 1; end
          else begin m_ver = 1; m_start = 1; m_vc = 0; end
        end else m_err = 6;
      end
    end
    if (was_ver) begin
      m_vc++;
      if (dn) begin
        if (ok) begin m_ver = 0; m_done = 1; m_ok = 1; end
        else verify_fail(4);
      end
`ifdef BOOT_SIG_TIMEOUT_EN
      else if (m_vc >= TO) verify_fail(5);
`endif
    end
  endfunction

  function automatic exp_t make_exp(int unsigned tag);
    exp_t e;
    int sg, ix, k;
    e.cyc = tag;
    if (m_w < PKW) begin sg = 0; ix = m_w; end
    else if (m_w < PKW + SGW) begin sg = 1; ix = m_w - PKW; end
    else if (m_w < TOT) begin sg = 2; ix = m_w - PKW - SGW; end
    else begin sg = 3; ix = 0; end
    e.rd = '0;
    e.rd[31] = m_done; e.rd[30] = m_ok; e.rd[29] = m_lock;
    e.rd[27:24] = 4'(m_err); e.rd[23:20] = 4'(m_att);
    e.rd[19:18] = 2'(sg); e.rd[7:0] = 8'(ix);
    e.ok = m_done && m_ok;
    e.st = m_start;
    // Shift-in from the top: the k words seen so far occupy the top k slots
    e.pk = '0; k = clamp(m_w, PKW);
    for (int j = PKW - k; j < PKW; j++) e.pk[j*32 +: 32] = mw[j - (PKW - k)];
    e.sg = '0; k = clamp(m_w - PKW, SGW);
    for (int j = SGW - k; j < SGW; j++) e.sg[j*32 +: 32] = mw[PKW + j - (SGW - k)];
    e.hs = '0; k = clamp(m_w - PKW - SGW, HSW);
    for (int j = HSW - k; j < HSW; j++) e.hs[j*32 +: 32] = mw[PKW + SGW + j - (HSW - k)];
    return e;
  endfunction

  // Monitor: compare every output against the entry scheduled for this cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("rd_data", 512'(rd_data), 512'(e.rd));
      check("sig_ok", 512'(sig_ok), 512'(e.ok));
      check("vfy_start_o", 512'(vfy_start_o), 512'(e.st));
      check("vfy_pubkey_o", 512'(vfy_pubkey_o), 512'(e.pk));
      check("vfy_sig_o", 512'(vfy_sig_o), 512'(e.sg));
      check("vfy_hash_o", 512'(vfy_hash_o), 512'(e.hs));
    end
  end

  task automatic tick(input bit we, input bit ad, input logic [31:0] d,
                      input bit dn, input bit ok);
    @(posedge clk); #1;
    wr_en = we; wr_addr = ad; wr_data = d; vfy_done_i = dn; vfy_ok_i = ok;
    lock_i = lock_req; key_revoked_i = rev_req;
    if (!rst_n) model_reset();
    else model_step(we, ad, d, dn, ok);
    q.push_back(make_exp(cyc + 1));
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk); #1;
    rst_n = v; wr_en = 0; vfy_done_i = 0; vfy_ok_i = 0;
    lock_i = lock_req; key_revoked_i = rev_req;
    while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
    model_reset();
    q.push_back(make_exp(cyc));
    q.push_back(make_exp(cyc + 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, $urandom, 0, 0);
  endtask

  task automatic ctrl(input bit st, input bit ab, input logic [3:0] kid);
    tick(1, 1, {20'd0, kid, 6'd0, ab, st}, 0, 0);
  endtask

  task automatic stream(input int slot, input int bad);
    logic [31:0] w;
    for (int i = 0; i < TOT; i++) begin
      w = (i < PKW) ? ktab[slot][i] : $urandom;
      if (i == bad) w = w ^ 32'h1;
      tick(1, 0, w, 0, 0);
    end
  endtask

  task automatic reset_cycle();
    set_rst(0); idle(1); set_rst(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < PKW; i++) begin
        ktab[k][i] = $urandom;
        key_table_i[(k*PKW + i)*32 +: 32] = ktab[k][i];
      end
    model_reset();
    idle(3);
    set_rst(1);
    idle(2);

    // Successful verification, verifier answers 5 cycles after start
    stream(0, -1);
    ctrl(1, 0, 4'd0);
    idle(4);
    tick(0, 0, 0, 1, 1);
    idle(2);
    @(negedge clk);
    check("pass_status_const", 512'(rd_data), 512'(32'hC00C0000));
    ctrl(0, 1, 4'd0);
    tick(1, 0, $urandom, 0, 0);
    idle(2);

    // Key checks: bad id, revoked slot, mismatched PK word 3
    reset_cycle();
    stream(0, -1); ctrl(1, 0, 4'd5); idle(2); ctrl(0, 1, 4'd0);
    rev_req = 4'b0001;
    stream(0, -1); ctrl(1, 0, 4'd0); idle(2); ctrl(0, 1, 4'd0);
    rev_req = '0;
    stream(0, 3); ctrl(1, 0, 4'd0); idle(2); ctrl(0, 1, 4'd0);

    // Three verifier rejections lead to lockout; abort then ignored
    for (int a = 0; a < MA; a++) begin
      stream(1, -1); ctrl(1, 0, 4'd1); idle(2);
      tick(0, 0, 0, 1, 0); idle(1);
      ctrl(0, 1, 4'd0); idle(1);
    end
    @(negedge clk);
    check("lockout_bit", 512'(rd_data[29]), 512'(1'b1));
    idle(2);

    // Locked writes ignored, start in COLLECT
    reset_cycle();
    lock_req = 1'b1;
    repeat (10) tick(1, 0, $urandom, 0, 0);
    lock_req = 1'b0;
    ctrl(1, 0, 4'd0); idle(1);
    repeat (5) tick(1, 0, $urandom, 0, 0);
    ctrl(1, 0, 4'd0); idle(1);

    // Silent verifier (times out when the timeout build is enabled)
    reset_cycle();
    stream(2, -1); ctrl(1, 0, 4'd2);
    idle(TO + 4);
    tick(0, 0, 0, 1, 1);
    idle(2);

    // Reset 3 cycles into VERIFY, late done afterwards
    reset_cycle();
    stream(3, -1); ctrl(1, 0, 4'd3); idle(2);
    set_rst(0); idle(2); set_rst(1);
    tick(0, 0, 0, 1, 1);
    idle(2);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      lock_req = ($urandom_range(0, 99) < 6);
      if (r < 2) begin
        rev_req = 4'($urandom_range(0, 15)) & 4'b1110;
        reset_cycle();
      end else if (m_ver && r < 40) begin
        tick(0, 0, $urandom, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end else if (r < 70) begin
        tick(1, 0, (m_w < PKW && $urandom_range(0, 9) != 0) ? ktab[0][m_w] : $urandom, 0, 0);
      end else if (r < 80) begin
        ctrl(1, 0, ($urandom_range(0, 9) < 7) ? 4'd0 : 4'($urandom_range(0, 5)));
      end else if (r < 86) begin
        ctrl(0, 1, 4'd0);
      end else begin
        tick(0, 0, $urandom, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      end
    end
    lock_req = 1'b0;
    idle(3);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 512'(q.size() <= 1), 512'(1'b1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
